button_conditioner: RTL
=======================

// Module: button_conditioner
// PURPOSE
// Conditions the four raw board push-buttons (izq, der, fire, reload) before they reach
// the game top level, which feeds them to Gun, Shot_Builder and the bullet counter.
// Per button: 2-flop synchronizer, then counter debounce, giving a clean level and a 1-cycle press pulse.
// izq/der additionally get hold-to-auto-repeat step pulses for gun movement.
// PARAMETERS
// DEBOUNCE_CYCLES  1000000   cycles synced input must differ from stable level before it is accepted (20 ms @50 MHz)
// REPEAT_DELAY     25000000  cycles from first izq/der step to first auto-repeat step
// REPEAT_RATE      5000000   cycles between subsequent auto-repeat steps
// CNT_W            25        width of debounce and repeat counters; must hold max(params)-1
// PORTS
// clk50mhz      in   1  system clock, 50 MHz
// reset         in   1  synchronous, active-high reset
// izq_raw       in   1  raw left button, asynchronous
// der_raw       in   1  raw right button, asynchronous
// fire_raw      in   1  raw fire button, asynchronous
// reload_raw    in   1  raw reload button, asynchronous
// izq           out  1  debounced left level
// der           out  1  debounced right level
// fire          out  1  debounced fire level
// reload        out  1  debounced reload level
// fire_pulse    out  1  1-cycle pulse on debounced fire press
// reload_pulse  out  1  1-cycle pulse on debounced reload press
// izq_step      out  1  1-cycle left step: on press, then auto-repeat while held
// der_step      out  1  1-cycle right step: on press, then auto-repeat while held
// BEHAVIOUR
// - Single clock domain (clk50mhz). All flops are cleared by synchronous active-high reset.
// - Reset values: all outputs 0, sync flops 0, stable levels 0, all counters 0, both repeat FSMs in IDLE.
// - Sync: s1<=raw; s2<=s1. A raw change is visible on s2 2 cycles later.
// - Debounce, per channel, with counter cnt and stable level lvl:
//   - If s2==lvl: cnt<=0.
//   - Else if cnt==DEBOUNCE_CYCLES-1: lvl<=s2; cnt<=0.
//   - Else: cnt<=cnt+1.
//   - Any bounce back to lvl restarts the count from 0.
//   - Latency from a clean raw edge to the level output is 2+DEBOUNCE_CYCLES cycles.
// - Press pulses: fire_pulse/reload_pulse are registered from the same update condition (lvl 0->1).
//   - The pulse is high exactly in the first cycle the level reads 1.
//   - A release (1->0) gives no pulse.
// - Repeat FSM, one per izq/der, with counter rcnt; states IDLE, DELAY, REPEAT.
//   - IDLE: on the level's rising update, step=1, rcnt<=0, go to DELAY.
//   - DELAY: if level==0, go to IDLE.
//     Else if rcnt==REPEAT_DELAY-1: step=1, rcnt<=0, go to REPEAT. Else rcnt++.
//   - REPEAT: if level==0, go to IDLE.
//     Else if rcnt==REPEAT_RATE-1: step=1, rcnt<=0. Else rcnt++.
//   - Release never produces a step. Step spacing is exactly REPEAT_DELAY, then REPEAT_RATE, cycles.
// - Conflict: while izq and der are both 1, both steps are forced 0 and both FSMs are forced to IDLE.
//   - A button still held after the other releases produces no step until it is released and pressed again.
//   - The level outputs are unaffected by the conflict rule.
// - Reset asserted mid-debounce or mid-repeat drops everything to reset values the next edge.
//   - A button held through reset is re-reported only after a full 2+DEBOUNCE_CYCLES qualification.
// - Counters never wrap: each is cleared at its terminal value.
// TESTING (bench params: DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_RATE=3)
// 1 fire_raw 0->1 clean before edge k -> fire=1 and fire_pulse=1 after edge k+5; pulse low after k+6.
//   Release -> fire=0 after 6 cycles, no pulse.
// 2 fire_raw glitches high 3 cycles, low 1, high 3 -> fire stays 0, no pulse.
//   Then steady high -> fire=1 exactly 6 cycles after the last low-to-high edge.
// 3 izq_raw held 40 cycles -> izq_step pulses at t0, t0+10, t0+13, t0+16, ..., until release. No step on release.
// 4 izq held, der pressed at t0+5 -> no steps from either while both are high.
//   Release der -> izq gives no further steps until re-pressed.
// 5 reload held; reset for 1 cycle mid-DELAY on izq -> all outputs 0 next cycle.
//   reload=1 again 6 cycles after reset deasserts, with reload_pulse=1 in that cycle.
// 6 all four raw inputs toggled together -> each channel is independent; the level timing of test 1 holds for all four.

Source files
------------

// File: rtl/button_conditioner.sv
// Conditions the four raw push-buttons (izq, der, fire, reload) for the game top level.
// Each button gets a 2-flop synchronizer and a counter debounce that yields a clean level.
// fire/reload also produce a 1-cycle press pulse. izq/der produce step pulses: one step on
// press, then auto-repeat steps while the button is held.
//
// Ports:
//   clk50mhz      system clock
//   reset         synchronous, active-high reset
//   *_raw         raw asynchronous button inputs
//   izq/der/fire/reload       debounced levels
//   fire_pulse/reload_pulse   1-cycle pulse on debounced press
//   izq_step/der_step         1-cycle step on press, then auto-repeat while held
module button_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_RATE     = 5000000,
  parameter int unsigned CNT_W           = 25
) (
  input  logic clk50mhz,
  input  logic reset,
  input  logic izq_raw,
  input  logic der_raw,
  input  logic fire_raw,
  input  logic reload_raw,
  output logic izq,
  output logic der,
  output logic fire,
  output logic reload,
  output logic fire_pulse,
  output logic reload_pulse,
  output logic izq_step,
  output logic der_step
);

  // Channel order: 0 izq, 1 der, 2 fire, 3 reload.
  localparam int unsigned NumBtn = 4;
  localparam int unsigned NumRep = 2;

  localparam logic [CNT_W-1:0] DbLast    = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DelayLast = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RateLast  = CNT_W'(REPEAT_RATE - 1);

  typedef enum logic [1:0] {StIdle, StDelay, StRepeat} rep_state_e;

  logic [NumBtn-1:0] raw;
  logic [NumBtn-1:0] s1_q, s1_d, s2_q, s2_d;
  logic [NumBtn-1:0] lvl_q, lvl_d;
  logic [NumBtn-1:0] rise;
  logic [CNT_W-1:0]  db_cnt_q [NumBtn];
  logic [CNT_W-1:0]  db_cnt_d [NumBtn];

  logic [1:0]        pulse_q, pulse_d;

  rep_state_e        rep_state_q [NumRep];
  rep_state_e        rep_state_d [NumRep];
  logic [CNT_W-1:0]  rcnt_q [NumRep];
  logic [CNT_W-1:0]  rcnt_d [NumRep];
  logic [NumRep-1:0] step_q, step_d;
  logic              conflict;

  assign raw = {reload_raw, fire_raw, der_raw, izq_raw};

  // Synchronizer and debounce.
  always_comb begin
    s1_d = raw;
    s2_d = s1_q;
    for (int i = 0; i < NumBtn; i++) begin
      lvl_d[i]    = lvl_q[i];
      db_cnt_d[i] = db_cnt_q[i];
      rise[i]     = 1'b0;
      if (s2_q[i] == lvl_q[i]) begin
        db_cnt_d[i] = '0;
      end else if (db_cnt_q[i] == DbLast) begin
        lvl_d[i]    = s2_q[i];
        db_cnt_d[i] = '0;
        rise[i]     = s2_q[i];
      end else begin
        db_cnt_d[i] = db_cnt_q[i] + CNT_W'(1);
      end
    end
  end

  assign pulse_d = {rise[3], rise[2]};

  // Conflict is judged on next-cycle levels so a registered step never coincides with
  // both levels reading 1.
  assign conflict = lvl_d[0] & lvl_d[1];

  // Repeat FSMs for izq/der. They follow lvl_d so the step lines up with the level output
  // and a release never emits a step.
  always_comb begin
    for (int j = 0; j < NumRep; j++) begin
      rep_state_d[j] = rep_state_q[j];
      rcnt_d[j]      = rcnt_q[j];
      step_d[j]      = 1'b0;
      case (rep_state_q[j])
        StIdle: begin
          if (rise[j]) begin
            step_d[j]      = 1'b1;
            rcnt_d[j]      = '0;
            rep_state_d[j] = StDelay;
          end
        end
        StDelay: begin
          if (!lvl_d[j]) begin
            rcnt_d[j]      = '0;
            rep_state_d[j] = StIdle;
          end else if (rcnt_q[j] == DelayLast) begin
            step_d[j]      = 1'b1;
            rcnt_d[j]      = '0;
            rep_state_d[j] = StRepeat;
          end else begin
            rcnt_d[j] = rcnt_q[j] + CNT_W'(1);
          end
        end
        StRepeat: begin
          if (!lvl_d[j]) begin
            rcnt_d[j]      = '0;
            rep_state_d[j] = StIdle;
          end else if (rcnt_q[j] == RateLast) begin
            step_d[j] = 1'b1;
            rcnt_d[j] = '0;
          end else begin
            rcnt_d[j] = rcnt_q[j] + CNT_W'(1);
          end
        end
        default: begin
          rcnt_d[j]      = '0;
          rep_state_d[j] = StIdle;
        end
      endcase
      // Pressing both directions cancels movement until a fresh press.
      if (conflict) begin
        step_d[j]      = 1'b0;
        rcnt_d[j]      = '0;
        rep_state_d[j] = StIdle;
      end
    end
  end

  always_ff @(posedge clk50mhz) begin
    if (reset) begin
      s1_q    <= '0;
      s2_q    <= '0;
      lvl_q   <= '0;
      pulse_q <= '0;
      step_q  <= '0;
      for (int i = 0; i < NumBtn; i++) begin
        db_cnt_q[i] <= '0;
      end
      for (int j = 0; j < NumRep; j++) begin
        rcnt_q[j]      <= '0;
        rep_state_q[j] <= StIdle;
      end
    end else begin
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      lvl_q   <= lvl_d;
      pulse_q <= pulse_d;
      step_q  <= step_d;
      for (int i = 0; i < NumBtn; i++) begin
        db_cnt_q[i] <= db_cnt_d[i];
      end
      for (int j = 0; j < NumRep; j++) begin
        rcnt_q[j]      <= rcnt_d[j];
        rep_state_q[j] <= rep_state_d[j];
      end
    end
  end

  assign izq          = lvl_q[0];
  assign der          = lvl_q[1];
  assign fire         = lvl_q[2];
  assign reload       = lvl_q[3];
  assign fire_pulse   = pulse_q[0];
  assign reload_pulse = pulse_q[1];
  assign izq_step     = step_q[0];
  assign der_step     = step_q[1];

endmodule
